local_position_sched: RTL and testbench
=======================================

Name: local_position_sched

Overview:
- Round-robin scheduler that shares one local_position lookup unit between NUM_REQ conv requesters.
- Accepts per-requester pic index requests and sequences the lookup: one-cycle index_valid pulse, then wait for pos_valid.
- Returns the x/y position to the granted requester, tagged one-hot.
- Rejects out-of-range indices locally, without issuing a lookup.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 4, index width (= `INDEX_PX)
- POS_W, 2, position width (= `INDEX_PX_WIDE)
- MAX_INDEX, 3, largest index the lookup unit maps
- TIMEOUT_CYC, 16, WAIT cycle limit (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_index  in  NUM_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W]
- req_ready  out  NUM_REQ  one-hot grant pulse
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_x  out  POS_W  returned x
- rsp_y  out  POS_W  returned y
- rsp_err  out  1  response is an error (range or timeout)
- lp_index  out  IDX_W  to lookup pic_index
- lp_index_valid  out  1  to lookup pic_index_valid
- lp_x  in  POS_W  from lookup pic_index_x
- lp_y  in  POS_W  from lookup pic_index_y
- lp_pos_valid  in  1  from lookup pic_pos_valid
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- All outputs are registered. Synchronous reset (rst=1 at a clk edge) applies these values:
  - state IDLE, RR pointer 0
  - req_ready, rsp_valid, lp_index_valid, busy, rsp_err, err_timeout = 0
  - rsp_x, rsp_y, lp_index = 0
- Reset mid-operation aborts the transaction. No response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
  - Latch id and index; pulse req_ready[id] for one cycle (the cycle after the decision).
  - ptr <= (id+1) mod NUM_REQ.
  - If index > MAX_INDEX: go to RESP with rsp_err=1, x=y=0. No lookup is issued.
  - Otherwise go to ISSUE.
- ISSUE: lp_index_valid=1 for exactly this one cycle, lp_index=latched index; then go to WAIT.
- WAIT:
  - lp_index is held stable; lp_index_valid=0.
  - On lp_pos_valid=1, capture lp_x/lp_y into rsp_x/rsp_y, rsp_err=0, go to RESP.
- RESP: rsp_valid[id]=1 for one cycle; rsp_x/y/err are valid this cycle; then go to IDLE.
- Latency, request seen in IDLE at cycle T:
  - req_ready at T+1; lp_index_valid at T+1.
  - rsp_valid one cycle after the lp_pos_valid cycle.
  - Range-error path: rsp_valid at T+1, same cycle as req_ready.
- Requester rules:
  - Hold req_valid and req_index until req_ready.
  - Withdrawing before grant is allowed and is never granted.
  - A requester may re-request in the RESP cycle; it is arbitrated in the following IDLE.
- Simultaneous requests: exactly one grant per transaction, no starvation; every valid requester is served within NUM_REQ transactions.
- lp_pos_valid outside WAIT (IDLE/ISSUE/RESP) is ignored. This covers stray or late pulses, and the unreset lookup regs after power-up.
- Back-to-back: RESP→IDLE→ISSUE gives ≥2 cycles between lookup valid pulses, matching the lookup unit's return to its idle state.
- rsp_x/rsp_y/rsp_err hold their last value outside RESP.
- busy=1 in ISSUE/WAIT/RESP.

Optional Feature:
- Macro: LP_SCHED_TIMEOUT_EN
- Defined:
  - Counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with no lp_pos_valid, go to RESP with rsp_err=1, x=y=0, and set err_timeout=1.
  - err_timeout stays sticky until rst.
  - lp_pos_valid arriving in the same cycle the limit is reached wins (normal response).
- Undefined: WAIT has no time limit; err_timeout is tied to 0. The port exists in both builds.

Test Plan:
- Bench wraps a real lookup unit, rstn = ~rst.
- Single request: req_valid[0]=1, index 0 → req_ready=4'b0001 one cycle; lp_index_valid one cycle; rsp_valid=4'b0001 with x=2, y=2, err=0.
- Index sweep, requester 2, indices 1,2,3 back-to-back → (x,y) = (1,1), (2,1), (1,2); lp_index_valid pulses ≥4 cycles apart; no overlap.
- All four requesters held valid with indices 0..3 for 8 transactions → grant order 0,1,2,3,0,1,2,3; each rsp_valid one-hot matches the preceding grant.
- Range error: index 4'd9 on requester 1 → req_ready and rsp_valid[1] in the same cycle, rsp_err=1, x=y=0, lp_index_valid never asserted.
- Reset while in WAIT, then stray lp_pos_valid pulse → no rsp_valid, all outputs at reset values; a subsequent request completes normally.
- With LP_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, lookup stub never responds → rsp_err=1 and err_timeout=1 exactly 16 WAIT cycles after ISSUE; err_timeout persists until rst.

Source files
------------

// File: rtl/local_position_sched.sv
// Round-robin arbiter that time-shares one local_position lookup unit across NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining LP_SCHED_TIMEOUT_EN.
module local_position_sched #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 4,
  parameter int POS_W       = 2,
  parameter int MAX_INDEX   = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [POS_W-1:0]         rsp_x,
  output logic [POS_W-1:0]         rsp_y,
  output logic                     rsp_err,
  output logic [IDX_W-1:0]         lp_index,
  output logic                     lp_index_valid,
  input  logic [POS_W-1:0]         lp_x,
  input  logic [POS_W-1:0]         lp_y,
  input  logic                     lp_pos_valid,
  output logic                     busy,
  output logic                     err_timeout
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr, id;
  logic              win_found;
  logic [ID_W-1:0]   win_id, ptr_next;
  logic [IDX_W-1:0]  win_idx;
  logic [NUM_REQ-1:0] win_oh, id_oh;

  // Scan ptr, ptr+1, ... so the most recently served requester goes last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_id    = ID_W'(j);
      end
    end
    win_idx  = req_index[win_id*IDX_W +: IDX_W];
    ptr_next = (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
    win_oh   = '0;
    win_oh[win_id] = 1'b1;
    id_oh    = '0;
    id_oh[id] = 1'b1;
  end

`ifdef LP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      id             <= '0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_x          <= '0;
      rsp_y          <= '0;
      rsp_err        <= 1'b0;
      lp_index       <= '0;
      lp_index_valid <= 1'b0;
      busy           <= 1'b0;
`ifdef LP_SCHED_TIMEOUT_EN
      cnt            <= '0;
      err_timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= '0;
          rsp_valid <= '0;
          if (win_found) begin
            id        <= win_id;
            ptr       <= ptr_next;
            req_ready <= win_oh;
            busy      <= 1'b1;
            if (win_idx > IDX_W'(MAX_INDEX)) begin
              // Unmappable index: answer immediately, the lookup unit never sees it.
              rsp_valid <= win_oh;
              rsp_err   <= 1'b1;
              rsp_x     <= '0;
              rsp_y     <= '0;
              state     <= RESP;
            end else begin
              lp_index       <= win_idx;
              lp_index_valid <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          req_ready      <= '0;
          lp_index_valid <= 1'b0;
          state          <= WAIT;
`ifdef LP_SCHED_TIMEOUT_EN
          cnt            <= '0;
`endif
        end
        WAIT: begin
          if (lp_pos_valid) begin
            rsp_x     <= lp_x;
            rsp_y     <= lp_y;
            rsp_err   <= 1'b0;
            rsp_valid <= id_oh;
            state     <= RESP;
          end
`ifdef LP_SCHED_TIMEOUT_EN
          else if (int'(cnt) == TIMEOUT_CYC - 1) begin
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= id_oh;
            err_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          req_ready <= '0;
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_local_position_sched.sv
// Directed bench for local_position_sched around a behavioral local_position lookup model.
module tb_local_position_sched;
  localparam int N = 4, IW = 4, PW = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*IW-1:0] req_index = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [PW-1:0] rsp_x, rsp_y, lp_x, lp_y;
  logic          rsp_err, lp_index_valid, lp_pos_valid, busy, err_timeout;
  logic [IW-1:0] lp_index;

  int checks = 0, errors = 0, cyc = 0;
  logic stall = 1'b0, stray = 1'b0, rstn;
  logic pv;

  local_position_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_err(rsp_err), .lp_index(lp_index), .lp_index_valid(lp_index_valid),
    .lp_x(lp_x), .lp_y(lp_y), .lp_pos_valid(lp_pos_valid), .busy(busy),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lookup model: registered one-cycle response, pic index -> (x,y).
  assign rstn = ~rst;
  always @(posedge clk) begin
    if (!rstn) begin
      pv <= 1'b0; lp_x <= '0; lp_y <= '0;
    end else begin
      pv <= lp_index_valid && !stall;
      if (lp_index_valid) begin
        case (lp_index)
          4'd0: begin lp_x <= 2'd2; lp_y <= 2'd2; end
          4'd1: begin lp_x <= 2'd1; lp_y <= 2'd1; end
          4'd2: begin lp_x <= 2'd2; lp_y <= 2'd1; end
          4'd3: begin lp_x <= 2'd1; lp_y <= 2'd2; end
          default: begin lp_x <= 2'd0; lp_y <= 2'd0; end
        endcase
      end
    end
  end
  assign lp_pos_valid = pv | stray;

  function automatic logic [1:0] exp_x(input int i);
    return (i == 0 || i == 2) ? 2'd2 : 2'd1;
  endfunction
  function automatic logic [1:0] exp_y(input int i);
    return (i == 0 || i == 3) ? 2'd2 : (i == 1 || i == 2) ? 2'd1 : 2'd0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req_ready, rsp_valid, lp_index_valid, busy, rsp_err, err_timeout, rsp_x, rsp_y, lp_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rr=%b rv=%b liv=%b busy=%b err=%b to=%b x=%0d y=%0d idx=%0d, need all 0",
               req_ready, rsp_valid, lp_index_valid, busy, rsp_err, err_timeout, rsp_x, rsp_y, lp_index);
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_index = '0;
    step();
    checks++;
    if (req_ready !== 4'b0001 || lp_index_valid !== 1'b1 || lp_index !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: rr=%b liv=%b idx=%0d busy=%b, need 0001 1 0 1", req_ready, lp_index_valid, lp_index, busy);
    end
    req_valid = '0;
    step();
    checks++;
    if (req_ready !== 4'b0000 || lp_index_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: rr=%b liv=%b, need 0000 0", req_ready, lp_index_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_x !== 2'd2 || rsp_y !== 2'd2 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: rv=%b x=%0d y=%0d err=%b, need 0001 2 2 0", rsp_valid, rsp_x, rsp_y, rsp_err);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_x !== 2'd2 || rsp_y !== 2'd2) begin
      errors++;
      $display("FAIL single_after: rv=%b busy=%b x=%0d y=%0d, need 0000 0 2 2 (held)", rsp_valid, busy, rsp_x, rsp_y);
    end
  endtask

  task automatic test_sweep();
    int last_issue = -100;
    for (int t = 1; t <= 3; t++) begin
      int n = 0;
      req_valid = 4'b0100; req_index = '0; req_index[2*IW +: IW] = IW'(t);
      while (req_ready === 4'b0000 && n < 20) begin step(); n++; end
      checks++;
      if (req_ready !== 4'b0100 || lp_index_valid !== 1'b1 || (cyc - last_issue) < 4) begin
        errors++;
        $display("FAIL sweep_issue%0d: rr=%b liv=%b gap=%0d, need 0100 1 >=4", t, req_ready, lp_index_valid, cyc - last_issue);
      end
      last_issue = cyc;
      req_valid = '0;
      n = 0;
      step();
      while (rsp_valid === 4'b0000 && n < 20) begin
        if (lp_index_valid !== 1'b0) begin
          errors++; $display("FAIL sweep_overlap%0d: lp_index_valid=1 while in flight", t);
        end
        step(); n++;
      end
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_x !== exp_x(t) || rsp_y !== exp_y(t) || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL sweep_rsp%0d: rv=%b x=%0d y=%0d err=%b, need 0100 %0d %0d 0", t, rsp_valid, rsp_x, rsp_y, rsp_err, exp_x(t), exp_y(t));
      end
    end
    step(); step();
  endtask

  task automatic test_round_robin();
    do_reset();
    req_index = {4'd3, 4'd2, 4'd1, 4'd0};
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      int n = 0;
      logic [N-1:0] g, eg;
      eg = 4'b0001 << (t % 4);
      while (req_ready === 4'b0000 && n < 20) begin step(); n++; end
      g = req_ready;
      checks++;
      if (g !== eg) begin
        errors++; $display("FAIL rr_grant%0d: got %b need %b", t, g, eg);
      end
      n = 0;
      step();
      while (rsp_valid === 4'b0000 && n < 20) begin step(); n++; end
      if (t == 7) req_valid = '0;
      checks++;
      if (rsp_valid !== eg || rsp_x !== exp_x(t % 4) || rsp_y !== exp_y(t % 4)) begin
        errors++;
        $display("FAIL rr_rsp%0d: rv=%b x=%0d y=%0d need %b %0d %0d", t, rsp_valid, rsp_x, rsp_y, eg, exp_x(t % 4), exp_y(t % 4));
      end
    end
    step(); step();
  endtask

  task automatic test_range_error();
    int seen = 0;
    req_valid = 4'b0010; req_index = '0; req_index[1*IW +: IW] = 4'd9;
    step();
    req_valid = '0;
    if (lp_index_valid) seen++;
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_x !== 2'd0 || rsp_y !== 2'd0) begin
      errors++;
      $display("FAIL range_rsp: rr=%b rv=%b err=%b x=%0d y=%0d, need 0010 0010 1 0 0", req_ready, rsp_valid, rsp_err, rsp_x, rsp_y);
    end
    for (int k = 0; k < 4; k++) begin step(); if (lp_index_valid) seen++; end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL range_no_lookup: lp_index_valid cycles=%0d busy=%b, need 0 0", seen, busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int n = 0, bad = 0;
    stall = 1'b1;
    req_valid = 4'b0001; req_index = {4'd0, 4'd0, 4'd0, 4'd1};
    step(); req_valid = '0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL wait_stalled: busy=%b to=%b, need 1 0", busy, err_timeout);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, lp_index_valid, busy, rsp_err, rsp_x, rsp_y, lp_index} !== '0) begin
      errors++;
      $display("FAIL wait_reset_outputs: rr=%b rv=%b liv=%b busy=%b idx=%0d, need all 0", req_ready, rsp_valid, lp_index_valid, busy, lp_index);
    end
    stray = 1'b1; step(); stray = 1'b0;
    for (int k = 0; k < 4; k++) begin if (rsp_valid !== '0 || busy !== 1'b0) bad++; step(); end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stray_ignored: %0d cycles with activity, need 0", bad);
    end
    stall = 1'b0;
    req_valid = 4'b1000; req_index = {4'd3, 4'd0, 4'd0, 4'd0};
    step(); req_valid = '0;
    while (rsp_valid === 4'b0000 && n < 20) begin step(); n++; end
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_x !== 2'd1 || rsp_y !== 2'd2 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_rsp: rv=%b x=%0d y=%0d err=%b, need 1000 1 2 0", rsp_valid, rsp_x, rsp_y, rsp_err);
    end
    step(); step();
  endtask

`ifdef LP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0, t0;
    stall = 1'b1;
    req_valid = 4'b0100; req_index = {4'd0, 4'd2, 4'd0, 4'd0};
    step(); req_valid = '0; t0 = cyc;
    while (rsp_valid === 4'b0000 && n < 40) begin step(); n++; end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || err_timeout !== 1'b1 || (cyc - t0) != 17 || rsp_x !== 2'd0) begin
      errors++;
      $display("FAIL timeout_rsp: rv=%b err=%b to=%b dt=%0d x=%0d, need 0100 1 1 17 0", rsp_valid, rsp_err, err_timeout, cyc - t0, rsp_x);
    end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: to=%b need 1", err_timeout);
    end
    do_reset();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: to=%b need 0", err_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_round_robin();
    test_range_error();
    test_reset_in_wait();
`ifdef LP_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
